// File: rtl/router_in_deser.sv
// router_in_deser: bit-serial to byte converter for one router source port.
// Decodes a 4-bit LSB-first destination, skips a fixed pad gap, then
// assembles LSB-first data bytes into a one-entry valid/ready output register.
module router_in_deser #(
  parameter int PAD_CYCLES = 5
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       frame_n,
  input  logic       valid_n,
  input  logic       din,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] out_dst,
  output logic       out_sop,
  output logic       out_eop,
  output logic       err_frame,
  output logic       overrun,
  output logic       busy
);

  localparam int PAD_W = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(PAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ADDR, PAD, DATA} state_t;

  state_t           state_q,     state_d;
  logic [3:0]       dst_q,       dst_d;
  logic [2:0]       bit_cnt_q,   bit_cnt_d;
  logic [PAD_W-1:0] pad_cnt_q,   pad_cnt_d;
  logic [6:0]       shreg_q,     shreg_d;
  logic             first_q,     first_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q,  out_data_d;
  logic [3:0]       out_dst_q,   out_dst_d;
  logic             out_sop_q,   out_sop_d;
  logic             out_eop_q,   out_eop_d;
  logic             err_q,       err_d;
  logic             overrun_q,   overrun_d;

  logic             byte_done;
  logic             load;

  // State and output registers; everything returns to zero/IDLE on reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      dst_q       <= '0;
      bit_cnt_q   <= '0;
      pad_cnt_q   <= '0;
      shreg_q     <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dst_q   <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      bit_cnt_q   <= bit_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      shreg_q     <= shreg_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dst_q   <= out_dst_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Protocol decode FSM plus the one-entry output buffer next-state logic.
  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    bit_cnt_d   = bit_cnt_q;
    pad_cnt_d   = pad_cnt_q;
    shreg_d     = shreg_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_dst_d   = out_dst_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    err_d       = 1'b0;
    overrun_d   = overrun_q;
    byte_done   = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!frame_n) begin
          dst_d     = {3'b000, din};
          bit_cnt_d = 3'd1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (frame_n) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          dst_d[bit_cnt_q[1:0]] = din;
          if (bit_cnt_q == 3'd3) begin
            pad_cnt_d = '0;
            state_d   = PAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PAD: begin
        if (frame_n) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (pad_cnt_q == PAD_LAST) begin
          bit_cnt_d = 3'd0;
          first_d   = 1'b1;
          state_d   = DATA;
        end else begin
          pad_cnt_d = pad_cnt_q + PAD_W'(1);
        end
      end
      DATA: begin
        if (!valid_n) begin
          // LSB-first: shifting right leaves bit 0 at shreg_q[0] after 7 bits.
          shreg_d   = {din, shreg_q[6:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
            first_d   = 1'b0;
            if (frame_n) state_d = IDLE;
          end else if (frame_n) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (frame_n) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A finished byte may enter only an empty slot or one draining this cycle.
    load = byte_done && (!out_valid_q || out_ready);
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = {din, shreg_q};
      out_dst_d   = dst_q;
      out_sop_d   = first_q;
      out_eop_d   = frame_n;
    end else begin
      if (byte_done) overrun_d = 1'b1;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_dst   = out_dst_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign err_frame = err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_router_in_deser.sv
// Bench for router_in_deser: scenario tasks drive the serial protocol,
// expected bytes go to a scoreboard queue, a negedge monitor pops them.
module tb_router_in_deser;

  logic       clock = 1'b0;
  logic       rst, frame_n, valid_n, din, out_ready;
  logic       out_valid, out_sop, out_eop, err_frame, overrun, busy;
  logic [7:0] out_data;
  logic [3:0] out_dst;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;

  // {dst, data, sop, eop}
  logic [13:0] exp_q[$];
  logic [7:0]  pkt_b[4];

  router_in_deser #(.PAD_CYCLES(5)) dut (
    .clock(clock), .rst(rst), .frame_n(frame_n), .valid_n(valid_n), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dst(out_dst), .out_sop(out_sop), .out_eop(out_eop),
    .err_frame(err_frame), .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: every negedge with valid&&ready is one transfer.
  always @(negedge clock) begin
    logic [13:0] exp;
    if (!rst) begin
      if (err_frame) err_seen++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got dst=%h data=%h sop=%b eop=%b required no byte",
                   out_dst, out_data, out_sop, out_eop);
        end else begin
          exp = exp_q.pop_front();
          if ({out_dst, out_data, out_sop, out_eop} !== exp) begin
            failures++;
            $display("FAIL sb_byte got dst=%h data=%h sop=%b eop=%b required dst=%h data=%h sop=%b eop=%b",
                     out_dst, out_data, out_sop, out_eop, exp[13:10], exp[9:2], exp[1], exp[0]);
          end
        end
      end
    end
  end

  task automatic drive_bit(input logic f, input logic v, input logic d);
    frame_n = f;
    valid_n = v;
    din     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_bit(1'b1, 1'b1, 1'b0);
  endtask

  // Sends pkt_b[0..nbytes-1] to dst; pushes the first n_push bytes as expected.
  // abort_at >= 0 raises frame_n on that data-bit index and stops there.
  task automatic send(input logic [3:0] dst, input int nbytes, input int n_push,
                      input bit gaps, input int abort_at, input bit chk_lat);
    int  bi;
    logic last;
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1, dst[i]);
    for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int j = 0; j < nbytes; j++) begin
      for (int k = 0; k < 8; k++) begin
        bi = j * 8 + k;
        if (gaps && bi > 0) drive_bit(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        if (bi == abort_at) begin
          drive_bit(1'b1, 1'b0, pkt_b[j][k]);
          return;
        end
        last = (j == nbytes - 1) && (k == 7);
        if (k == 7 && j < n_push) exp_q.push_back({dst, pkt_b[j], (j == 0), last});
        drive_bit(last, 1'b0, pkt_b[j][k]);
        if (k == 7 && chk_lat) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== pkt_b[j]) begin
            failures++;
            $display("FAIL byte_latency byte%0d got valid=%b data=%h required valid=1 data=%h",
                     j, out_valid, out_data, pkt_b[j]);
          end
        end
      end
    end
  endtask

  task automatic chk_drained(input string name, input int err_before);
    checks++;
    if (exp_q.size() != 0 || err_seen != err_before) begin
      failures++;
      $display("FAIL %s got pending=%0d errs=%0d required pending=0 errs=%0d",
               name, exp_q.size(), err_seen - err_before, 0);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    checks++;
    if ({out_valid, out_data, out_dst, out_sop, out_eop, err_frame, overrun, busy} !== 19'd0) begin
      failures++;
      $display("FAIL %s got valid=%b data=%h dst=%h sop=%b eop=%b err=%b ovr=%b busy=%b required all zero",
               name, out_valid, out_data, out_dst, out_sop, out_eop, err_frame, overrun, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("reset_values");
    rst = 1'b0;
    idle(2);
    chk_reset_vals("idle_after_reset");
  endtask

  task automatic test_single(input bit gaps);
    int e0 = err_seen;
    out_ready = 1'b1;
    pkt_b[0] = 8'h55; pkt_b[1] = 8'haa;
    send(4'h3, 2, 2, gaps, -1, 1'b1);
    idle(3);
    chk_drained(gaps ? "gaps_drain" : "single_drain", e0);
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_status got ovr=%b busy=%b required ovr=0 busy=0", overrun, busy);
    end
  endtask

  task automatic test_backpressure;
    int e0 = err_seen;
    out_ready = 1'b0;
    pkt_b[0] = 8'h01; pkt_b[1] = 8'h02; pkt_b[2] = 8'h03;
    send(4'ha, 3, 1, 1'b0, -1, 1'b0);
    checks++;
    if ({out_valid, out_data, out_dst, out_sop, out_eop, overrun} !== {1'b1, 8'h01, 4'ha, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bp_hold got valid=%b data=%h dst=%h sop=%b eop=%b ovr=%b required valid=1 data=01 dst=a sop=1 eop=0 ovr=1",
               out_valid, out_data, out_dst, out_sop, out_eop, overrun);
    end
    idle(1);
    out_ready = 1'b1;
    idle(1);
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got valid=%b ovr=%b required valid=0 ovr=1", out_valid, overrun);
    end
    idle(3);
    chk_drained("bp_drain", e0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL bp_overrun_clear got ovr=%b required 0", overrun);
    end
  endtask

  task automatic test_short_frame;
    int e0 = err_seen;
    out_ready = 1'b1;
    pkt_b[0] = 8'h3c; pkt_b[1] = 8'ha5;
    send(4'h5, 2, 1, 1'b0, 12, 1'b1);
    checks++;
    if (err_frame !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL short_err got err=%b busy=%b required err=1 busy=0", err_frame, busy);
    end
    idle(1);
    checks++;
    if (err_frame !== 1'b0) begin
      failures++;
      $display("FAIL short_err_pulse got err=%b required 0", err_frame);
    end
    idle(2);
    chk_drained("short_first_byte", e0 + 1);
    pkt_b[0] = 8'h96;
    send(4'hf, 1, 1, 1'b0, -1, 1'b1);
    idle(3);
    chk_drained("short_next_pkt", e0 + 1);
  endtask

  task automatic test_abort(input bit in_pad);
    int e0 = err_seen;
    out_ready = 1'b1;
    drive_bit(1'b0, 1'b1, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0);
    if (in_pad) begin
      drive_bit(1'b0, 1'b1, 1'b1);
      drive_bit(1'b0, 1'b1, 1'b1);
      drive_bit(1'b0, 1'b1, 1'b0);
    end
    drive_bit(1'b1, 1'b1, 1'b0);
    checks++;
    if (err_frame !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s got err=%b busy=%b valid=%b required err=1 busy=0 valid=0",
               in_pad ? "abort_pad" : "abort_addr", err_frame, busy, out_valid);
    end
    idle(1);
    checks++;
    if (err_frame !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse got err=%b required 0", err_frame);
    end
    idle(2);
    chk_drained(in_pad ? "abort_pad_count" : "abort_addr_count", e0 + 1);
  endtask

  task automatic test_reset_mid;
    int e0;
    out_ready = 1'b0;
    pkt_b[0] = 8'h11;
    send(4'h2, 1, 0, 1'b0, -1, 1'b0);
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      failures++;
      $display("FAIL rmid_pending got valid=%b data=%h required valid=1 data=11", out_valid, out_data);
    end
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b0);
    chk_reset_vals("rmid_reset_values");
    rst = 1'b0;
    out_ready = 1'b1;
    e0 = err_seen;
    pkt_b[0] = 8'hff;
    send(4'h0, 1, 1, 1'b0, -1, 1'b1);
    idle(3);
    chk_drained("rmid_next_pkt", e0);
  endtask

  task automatic test_back_to_back;
    int e0 = err_seen;
    out_ready = 1'b1;
    pkt_b[0] = 8'h12;
    send(4'h7, 1, 1, 1'b0, -1, 1'b1);
    pkt_b[0] = 8'h34; pkt_b[1] = 8'h56;
    send(4'h9, 2, 2, 1'b0, -1, 1'b1);
    idle(3);
    chk_drained("b2b_drain", e0);
  endtask

  initial begin
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_backpressure();
    test_short_frame();
    test_abort(1'b0);
    test_abort(1'b1);
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_in_deser.md
# router_in_deser

Serial-to-parallel input stage for one router source port; it sits directly downstream of the per-port serial driver. It decodes the frame_n / valid_n / din bit-serial protocol into a 4-bit destination and a byte stream with start- and end-of-packet marks. It presents the result on a valid/ready byte interface to the router's switching logic. Instantiate one block per source port (16 in the router).

## Interface
- PAD_CYCLES, 5: number of cycles between the last address bit and the first data-phase cycle; din and valid_n are ignored during these cycles.
- clock  in  1  sole clock; all inputs sampled and all outputs updated on its rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_n  in  1  active-low packet frame; high on the final data bit.
- valid_n  in  1  active-low data-bit qualifier (data phase only).
- din  in  1  serial address/data bit.
- out_valid  out  1  out_data/out_dst/out_sop/out_eop hold a byte.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- out_data  out  8  assembled byte.
- out_dst  out  4  destination port of the packet carrying this byte.
- out_sop  out  1  byte is first of packet.
- out_eop  out  1  byte is last of packet.
- err_frame  out  1  one-cycle pulse: malformed packet aborted.
- overrun  out  1  sticky: a completed byte was dropped (output still occupied); cleared only by rst.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, ADDR, PAD, DATA.
- IDLE: frame_n=0 samples din as dst[0], bit_cnt=1, go ADDR.
- ADDR: each cycle store din into dst[bit_cnt] (LSB first). After dst[3] is stored go PAD with pad_cnt=0. frame_n=1 in ADDR -> err_frame, go IDLE.
- PAD: count PAD_CYCLES cycles, ignore din/valid_n, then go DATA with bit_cnt=0 and first=1. frame_n=1 in PAD -> err_frame, go IDLE.
- DATA, valid_n=0: shift din into shreg[bit_cnt] (LSB first), bit_cnt+1 (3-bit, wraps 7->0).
  - On the 8th bit a byte completes: data={din,shreg[6:0]}, sop=first, eop=frame_n, dst=latched dst; clear first.
  - If frame_n=1 on that 8th bit, go IDLE.
- DATA, valid_n=1, frame_n=0: idle bit slot, no change.
- DATA, frame_n=1 on a bit that is not the 8th, or with valid_n=1: err_frame, discard partial byte, go IDLE. Bytes already emitted are not recalled, and no byte carries eop.
- Zero-data packet (frame_n=1 in first DATA cycle): err_frame.
- Output register, one entry:
  - A completed byte loads it when empty, or when it is being accepted in the same cycle (out_valid && out_ready).
  - Otherwise the new byte is dropped and overrun is set. The FSM continues regardless.
- out_valid clears on acceptance with no simultaneous load.
- Reset values: state IDLE, out_valid=0, out_data=0, out_dst=0, out_sop=0, out_eop=0, err_frame=0, overrun=0, busy=0, all counters 0.
- rst mid-packet: immediate return to IDLE; the pending output byte is lost. The remainder of that packet is not valid input. The next frame_n=0 after rst deasserts starts a new packet.

## Timing
- Address bit 0 is sampled on the edge where frame_n is first low; bits 1..3 follow on consecutive edges.
- First data-phase sample is the (4+PAD_CYCLES+1)-th edge of the packet.
- Byte latency: out_valid is high in the cycle after the edge that sampled its 8th bit.
- Minimum packet length in clocks: 4 + PAD_CYCLES + 8·N.
- A new packet may start (frame_n=0) on the cycle immediately after the eop bit; IDLE is entered on that same edge.
- err_frame is high exactly one cycle, the cycle after the offending edge.
- Output fields are stable while out_valid && !out_ready.

## Test plan
- Single packet: dst=4'h3, data {8'h55,8'haa}, out_ready=1. Expect two bytes 8'h55 (sop=1, eop=0, dst=3) then 8'haa (sop=0, eop=1, dst=3). No err_frame, overrun=0.
- valid_n gaps: same packet with valid_n=1 inserted between every bit. Expect identical bytes, each 1 cycle after its 8th valid bit.
- Backpressure: 3-byte packet {8'h01,8'h02,8'h03}, out_ready=0 throughout. Expect 8'h01 held with sop=1, overrun=1 after the 2nd byte completes. Release out_ready: only 8'h01 is delivered.
- Short frame: frame_n=1 on the 5th bit of the second byte. Expect first byte emitted without eop, err_frame pulse, busy=0 next cycle. A following packet to dst=4'hF decodes correctly.
- Abort in PAD and in ADDR: frame_n=1 during pad cycle 2, and separately after addr bit 1. Expect err_frame pulse each time and no output bytes.
- Reset mid-DATA: rst=1 for one cycle after 3 data bits. Expect all outputs at reset values next cycle. A back-to-back packet dst=4'h0, data 8'hff yields 8'hff with sop=1, eop=1.
